demux_sel_sequencer: RTL and testbench

DEMUX_SEL_SEQUENCER -- requirements
Module: demux_sel_sequencer

---
 rtl/demux_sel_sequencer.sv | 168 ++++++++++++++++
 tb/tb_demux_sel_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
//   Scans the enabled channels of an 8-way demultiplexer, holding each
//   channel for dwell+1 cycles and routing serial data to it.
//
// Parameters
//   DWELL_W  width of the per-channel dwell count
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   single-cycle request to begin a scan pass (IDLE only)
//   abort  in   terminate an active scan
//   mask   in   [7:0] channel enable bits, bit k = channel k
//   dwell  in   [DWELL_W-1:0] cycles per channel minus one
//   din    in   serial data to be routed
//   s      out  [2:0] registered channel select
//   i      out  registered data (din delayed one cycle while scanning)
//   busy   out  high while a scan is active
//   done   out  one-cycle pulse at scan end
// Configuration
//   SEQ_LOOP_EN  when defined, the scan wraps to the lowest enabled channel
//                forever (done pulses at each wrap); only abort/reset end it.

module demux_sel_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               din,
    output logic [2:0]         s,
    output logic               i,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [2:0]         s_d;
    logic               i_d, busy_d, done_d;

    logic [2:0]         low_in;    // lowest set bit of the mask input
    logic [2:0]         next_ch;   // next higher set bit of the latched mask
    logic               has_next;
    logic               wrap;

    // Channel search helpers
    always_comb begin
        low_in   = '0;
        next_ch  = s;
        has_next = 1'b0;
        for (int unsigned k = 8; k > 0; k--) begin
            if (mask[k-1]) low_in = 3'(k-1);
        end
        for (int unsigned k = 0; k < 8; k++) begin
            if (!has_next && (k > 32'(s)) && mask_q[k]) begin
                has_next = 1'b1;
                next_ch  = 3'(k);
            end
        end
    end

`ifdef SEQ_LOOP_EN
    logic [2:0] low_q;

    always_comb begin
        low_q = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            if (mask_q[k-1]) low_q = 3'(k-1);
        end
    end
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= '0;
            i       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state   <= state_nxt;
            s       <= s_d;
            i       <= i_d;
            busy    <= busy_d;
            done    <= done_d;
            cnt     <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic; abort takes priority over the channel advance
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (mask != '0) ? HOLD : DONE;
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if ((cnt == '0) && !has_next) begin
`ifdef SEQ_LOOP_EN
                    state_nxt = HOLD;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values, registered above
    always_comb begin
        s_d     = s;
        cnt_d   = cnt;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        wrap    = 1'b0;
        case (state)
            IDLE: begin
                if (start && (mask != '0)) begin
                    mask_d  = mask;
                    dwell_d = dwell;
                    s_d     = low_in;
                    cnt_d   = dwell;
                end
            end
            HOLD: begin
                if (!abort) begin
                    if (cnt == '0) begin
                        if (has_next) begin
                            s_d   = next_ch;
                            cnt_d = dwell_q;
                        end else begin
`ifdef SEQ_LOOP_EN
                            s_d   = low_q;
                            cnt_d = dwell_q;
                            wrap  = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // i/busy reflect the state being entered so they line up with s
        i_d    = (state_nxt == HOLD) ? din : 1'b0;
        busy_d = (state_nxt == HOLD);
        done_d = (state_nxt == DONE) || wrap;
    end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
module tb_demux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] mask = '0;
    logic [3:0] dwell = '0;
    logic       din = 1'b0;
    logic [2:0] s;
    logic       i, busy, done;

    demux_sel_sequencer #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .mask  (mask),
        .dwell (dwell),
        .din   (din),
        .s     (s),
        .i     (i),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] s;
        logic       i;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] last_s   = '0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Compare one expected entry per cycle, away from the active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("s",    8'(s),    8'(mon_e.s));
            check("i",    8'(i),    8'(mon_e.i));
            check("busy", 8'(busy), 8'(mon_e.busy));
            check("done", 8'(done), 8'(mon_e.done));
        end
    end

    // Drive one cycle of inputs and push the expected outputs after the edge
    task automatic cyc(input logic st, input logic ab, input logic [7:0] m,
                       input logic [3:0] d, input logic [2:0] es,
                       input logic hold, input logic ed);
        exp_t e;
        @(negedge clk);
        start = st;
        abort = ab;
        mask  = m;
        dwell = d;
        din   = ~din;
        e.s    = es;
        e.i    = hold ? din : 1'b0;
        e.busy = hold;
        e.done = ed;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // One single-pass scan; abort_at = HOLD-cycle index carrying abort (-1: none)
    task automatic scan(input logic [7:0] m, input logic [3:0] d, input int abort_at);
        int seq[$];
        for (int k = 0; k < 8; k++)
            if (m[k])
                for (int r = 0; r <= int'(d); r++) seq.push_back(k);
        if (seq.size() == 0) begin
            cyc(1'b1, 1'b0, m, d, last_s, 1'b0, 1'b1);
        end else begin
            cyc(1'b1, 1'b0, m, d, 3'(seq[0]), 1'b1, 1'b0);
            for (int j = 0; j < seq.size(); j++) begin
                if (j == abort_at) begin
                    cyc(1'b0, 1'b1, 8'($urandom), 4'($urandom), 3'(seq[j]), 1'b0, 1'b1);
                    last_s = 3'(seq[j]);
                    break;
                end else if (j + 1 < seq.size()) begin
                    // mask/dwell scrambled and a stray start: all must be ignored
                    cyc(j == 1, 1'b0, 8'($urandom), 4'($urandom), 3'(seq[j+1]), 1'b1, 1'b0);
                end else begin
                    cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'(seq[j]), 1'b0, 1'b1);
                    last_s = 3'(seq[j]);
                end
            end
        end
        cyc(1'b0, 1'b0, 8'h00, 4'h0, last_s, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        #1;
        check("rst_s",    8'(s),    8'h00);
        check("rst_i",    8'(i),    8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_LOOP_EN
        cyc(1'b1, 1'b0, 8'h81, 4'd0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'd7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'd7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 8'h81, 4'd0, 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
`else
        scan(8'h00, 4'd0, -1);           // empty mask straight after reset
        scan(8'hA5, 4'd1, -1);           // 0,0,2,2,5,5,7,7 then done
        scan(8'h01, 4'd3, -1);           // data latency over 4 cycles
        scan(8'hFF, 4'd7, 18);           // abort on third cycle of channel 2
        cyc(1'b0, 1'b1, 8'hFF, 4'd1, last_s, 1'b0, 1'b0);  // abort in IDLE
        scan(8'h03, 4'd1, 1);            // abort coincides with counter==0
        scan(8'h42, 4'd0, -1);           // dwell=0
        scan(8'h80, 4'd15, -1);          // maximum dwell, top channel
        scan(8'h00, 4'd2, -1);           // empty mask keeps previous s

        // reset during HOLD on channel 4
        cyc(1'b1, 1'b0, 8'h30, 4'd3, 3'd4, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h30, 4'd3, 3'd4, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_s",    8'(s),    8'h00);
        check("midrst_i",    8'(i),    8'h00);
        check("midrst_busy", 8'(busy), 8'h00);
        check("midrst_done", 8'(done), 8'h00);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        last_s = '0;
        repeat (4) cyc(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'd0, 1'b0, 1'b0);
        scan(8'hA5, 4'd1, -1);
`endif

        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
